// File: rtl/rom_arbiter_if.sv
// Bundle of the fetch port, the data port and the ROM read port of rom_arbiter.
// The slave modport is the arbiter's view; master is the CPU/ROM side.
`timescale 1ns/1ps
interface rom_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;

  logic        d_req;
  logic [31:0] d_addr;
  logic [1:0]  d_size;
  logic        d_unsigned;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;

  logic [31:0] rom_addr;
  logic [31:0] rom_data;

  modport slave (
    input  if_req, if_addr, d_req, d_addr, d_size, d_unsigned, rom_data,
    output if_gnt, if_rvalid, if_rdata, if_err,
    output d_gnt, d_rvalid, d_rdata, d_err, rom_addr
  );

  modport master (
    output if_req, if_addr, d_req, d_addr, d_size, d_unsigned, rom_data,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    input  d_gnt, d_rvalid, d_rdata, d_err, rom_addr
  );
endinterface

// File: rtl/rom_arbiter.sv
// Shares one combinational ROM read port between instruction fetch and data reads.
// Data has priority; a saturating starve counter forces a fetch win after STARVE_LIMIT denials.
`timescale 1ns/1ps
module rom_arbiter #(
  parameter int unsigned ROM_SIZE     = 4194304,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  rom_arbiter_if.slave bus
);

  localparam int               CNT_W   = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
  localparam logic [32:0]      ROM_END = 33'(ROM_SIZE);

  // Range checks are done on 33 bits so an address near 0xFFFFFFFF cannot wrap into range.
  function automatic logic fetch_err(input logic [31:0] addr);
    logic [32:0] last;
    last = {1'b0, addr} + 33'd3;
    return (addr[1:0] != 2'b00) || (last >= ROM_END);
  endfunction

  function automatic logic data_err(input logic [31:0] addr, input logic [1:0] size);
    logic [32:0] last;
    logic        misal;
    last  = {1'b0, addr};
    misal = 1'b0;
    case (size)
      2'd0: begin
        last  = {1'b0, addr};
        misal = 1'b0;
      end
      2'd1: begin
        last  = {1'b0, addr} + 33'd1;
        misal = addr[0];
      end
      2'd2: begin
        last  = {1'b0, addr} + 33'd3;
        misal = |addr[1:0];
      end
      default: return 1'b1;
    endcase
    return misal || (last >= ROM_END);
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] word, input logic [1:0] size,
                                         input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] s;
    b = word[7:0];
    h = word[15:0];
    case (size)
      2'd0: begin
        s = b;
        return uns ? {24'd0, word[7:0]} : s;
      end
      2'd1: begin
        s = h;
        return uns ? {16'd0, word[15:0]} : s;
      end
      default: return word;
    endcase
  endfunction

  logic [CNT_W-1:0] starve_q, starve_d;
  logic             if_force, if_gnt, d_gnt;

  logic        if_rvalid_q, if_rvalid_d;
  logic [31:0] if_rdata_q,  if_rdata_d;
  logic        if_err_q,    if_err_d;
  logic        d_rvalid_q,  d_rvalid_d;
  logic [31:0] d_rdata_q,   d_rdata_d;
  logic        d_err_q,     d_err_d;

  always_comb begin
    if_force = bus.if_req && (starve_q == LIMIT);
    if_gnt   = bus.if_req && (!bus.d_req || if_force);
    d_gnt    = bus.d_req && !if_gnt;
  end

  always_comb begin
    starve_d = starve_q;
    if (!bus.if_req || if_gnt) begin
      starve_d = '0;
    end else if (starve_q != LIMIT) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  // The ROM port follows the winner; rom_data therefore always belongs to the granted request.
  always_comb begin
    if (if_gnt) begin
      bus.rom_addr = bus.if_addr;
    end else if (d_gnt) begin
      bus.rom_addr = bus.d_addr;
    end else begin
      bus.rom_addr = 32'd0;
    end
  end

  always_comb begin
    if_rvalid_d = if_gnt;
    if_err_d    = fetch_err(bus.if_addr);
    if_rdata_d  = if_err_d ? 32'd0 : bus.rom_data;
    d_rvalid_d  = d_gnt;
    d_err_d     = data_err(bus.d_addr, bus.d_size);
    d_rdata_d   = d_err_d ? 32'd0 : extend(bus.rom_data, bus.d_size, bus.d_unsigned);
  end

  // Response stage: one registered response per grant, visible the cycle after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q    <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= 32'd0;
      if_err_q    <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= 32'd0;
      d_err_q     <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      if_err_q    <= if_err_d;
      d_rvalid_q  <= d_rvalid_d;
      d_rdata_q   <= d_rdata_d;
      d_err_q     <= d_err_d;
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_err    = if_err_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_err     = d_err_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: vector table plus hand sequences for starvation and reset.
`timescale 1ns/1ps
module tb_rom_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rom_arbiter_if bus ();

  rom_arbiter #(.ROM_SIZE(4194304), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 256-byte ROM image aliased over the whole address space.
  logic [7:0] mem [256];
  logic [7:0] ra;
  always_comb begin
    ra = bus.rom_addr[7:0];
    bus.rom_data = {mem[ra + 8'd3], mem[ra + 8'd2], mem[ra + 8'd1], mem[ra]};
  end

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        ir;  logic [31:0] ia;
    logic        dr;  logic [31:0] da; logic [1:0] ds; logic du;
    logic        eig; logic edg; logic [31:0] erom;
    logic        eiv; logic [31:0] eid; logic eie;
    logic        edv; logic [31:0] edd; logic ede;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic ir, logic [31:0] ia, logic dr, logic [31:0] da,
                              logic [1:0] ds, logic du, logic eig, logic edg,
                              logic [31:0] erom, logic eiv, logic [31:0] eid, logic eie,
                              logic edv, logic [31:0] edd, logic ede);
    vec_t v;
    v.ir = ir;   v.ia = ia;   v.dr = dr;   v.da = da;   v.ds = ds;   v.du = du;
    v.eig = eig; v.edg = edg; v.erom = erom;
    v.eiv = eiv; v.eid = eid; v.eie = eie;
    v.edv = edv; v.edd = edd; v.ede = ede;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic [31:0] da, input logic [1:0] ds, input logic du);
    bus.if_req = ir; bus.if_addr = ia;
    bus.d_req = dr;  bus.d_addr = da; bus.d_size = ds; bus.d_unsigned = du;
  endtask

  // One cycle with fixed addresses (fetch 0x20, data word 0x40): check grants, then responses.
  task automatic step(input string nm, input logic ir, input logic dr,
                      input logic eig, input logic edg);
    @(negedge clk);
    drive(ir, 32'h20, dr, 32'h40, 2'd2, 1'b0);
    #1;
    chk({nm, "_if_gnt"}, 32'(bus.if_gnt), 32'(eig));
    chk({nm, "_d_gnt"},  32'(bus.d_gnt),  32'(edg));
    @(posedge clk);
    #1;
    chk({nm, "_if_rvalid"}, 32'(bus.if_rvalid), 32'(eig));
    chk({nm, "_d_rvalid"},  32'(bus.d_rvalid),  32'(edg));
    if (eig) chk({nm, "_if_rdata"}, bus.if_rdata, 32'h23222120);
    if (edg) chk({nm, "_d_rdata"},  bus.d_rdata,  32'h43424140);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
    rst_n = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 32'd0, 2'd0, 1'b0);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    chk("rst_d_rvalid",  32'(bus.d_rvalid),  32'd0);
    chk("rst_if_err",    32'(bus.if_err),    32'd0);
    chk("rst_d_err",     32'(bus.d_err),     32'd0);
    chk("rst_if_rdata",  bus.if_rdata,       32'd0);
    chk("rst_d_rdata",   bus.d_rdata,        32'd0);

    // First cycle after release: fetch 0x10
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'h10, 1'b0, 32'd0, 2'd0, 1'b0);
    #1;
    chk("f10_if_gnt",   32'(bus.if_gnt), 32'd1);
    chk("f10_d_gnt",    32'(bus.d_gnt),  32'd0);
    chk("f10_rom_addr", bus.rom_addr,    32'h10);
    @(posedge clk);
    #1;
    chk("f10_if_rvalid", 32'(bus.if_rvalid), 32'd1);
    chk("f10_if_rdata",  bus.if_rdata,       32'h44332211);
    chk("f10_if_err",    32'(bus.if_err),    32'd0);
    chk("f10_d_rvalid",  32'(bus.d_rvalid),  32'd0);

    @(negedge clk);
    mem[8'h11] = 8'h80;
    drive(1'b0, 32'd0, 1'b0, 32'd0, 2'd0, 1'b0);

    //          ir ia            dr da            ds    du   eig edg erom          eiv eid            eie edv edd            ede
    vq.push_back(mk(1, 32'h20,       0, 32'h0,        2'd0, 0, 1, 0, 32'h20,       1, 32'h23222120, 0, 0, 32'h0,        0));
    vq.push_back(mk(0, 32'h0,        1, 32'h11,       2'd0, 0, 0, 1, 32'h11,       0, 32'h0,        0, 1, 32'hFFFFFF80, 0));
    vq.push_back(mk(0, 32'h0,        1, 32'h11,       2'd0, 1, 0, 1, 32'h11,       0, 32'h0,        0, 1, 32'h00000080, 0));
    vq.push_back(mk(0, 32'h0,        1, 32'h10,       2'd0, 0, 0, 1, 32'h10,       0, 32'h0,        0, 1, 32'h00000011, 0));
    vq.push_back(mk(0, 32'h0,        1, 32'h80,       2'd1, 0, 0, 1, 32'h80,       0, 32'h0,        0, 1, 32'hFFFF8180, 0));
    vq.push_back(mk(0, 32'h0,        1, 32'h80,       2'd1, 1, 0, 1, 32'h80,       0, 32'h0,        0, 1, 32'h00008180, 0));
    vq.push_back(mk(0, 32'h0,        1, 32'h12,       2'd1, 0, 0, 1, 32'h12,       0, 32'h0,        0, 1, 32'h00004433, 0));
    vq.push_back(mk(0, 32'h0,        1, 32'h40,       2'd2, 0, 0, 1, 32'h40,       0, 32'h0,        0, 1, 32'h43424140, 0));
    vq.push_back(mk(0, 32'h0,        1, 32'h3,        2'd1, 0, 0, 1, 32'h3,        0, 32'h0,        0, 1, 32'h0,        1));
    vq.push_back(mk(1, 32'h3FFFFE,   0, 32'h0,        2'd0, 0, 1, 0, 32'h3FFFFE,   1, 32'h0,        1, 0, 32'h0,        0));
    vq.push_back(mk(0, 32'h0,        1, 32'hFFFFFFFE, 2'd0, 0, 0, 1, 32'hFFFFFFFE, 0, 32'h0,        0, 1, 32'h0,        1));
    vq.push_back(mk(1, 32'h3FFFFC,   0, 32'h0,        2'd0, 0, 1, 0, 32'h3FFFFC,   1, 32'hFFFEFDFC, 0, 0, 32'h0,        0));
    vq.push_back(mk(1, 32'h400000,   0, 32'h0,        2'd0, 0, 1, 0, 32'h400000,   1, 32'h0,        1, 0, 32'h0,        0));
    vq.push_back(mk(1, 32'h5,        0, 32'h0,        2'd0, 0, 1, 0, 32'h5,        1, 32'h0,        1, 0, 32'h0,        0));
    vq.push_back(mk(1, 32'hFFFFFFFC, 0, 32'h0,        2'd0, 0, 1, 0, 32'hFFFFFFFC, 1, 32'h0,        1, 0, 32'h0,        0));
    vq.push_back(mk(0, 32'h0,        1, 32'h0,        2'd3, 0, 0, 1, 32'h0,        0, 32'h0,        0, 1, 32'h0,        1));
    vq.push_back(mk(0, 32'h0,        1, 32'h2,        2'd2, 0, 0, 1, 32'h2,        0, 32'h0,        0, 1, 32'h0,        1));
    vq.push_back(mk(0, 32'h0,        1, 32'h3FFFFC,   2'd2, 0, 0, 1, 32'h3FFFFC,   0, 32'h0,        0, 1, 32'hFFFEFDFC, 0));
    vq.push_back(mk(0, 32'h0,        1, 32'h3FFFFE,   2'd1, 0, 0, 1, 32'h3FFFFE,   0, 32'h0,        0, 1, 32'hFFFFFFFE, 0));
    vq.push_back(mk(0, 32'h0,        1, 32'h3FFFFF,   2'd0, 1, 0, 1, 32'h3FFFFF,   0, 32'h0,        0, 1, 32'h000000FF, 0));
    vq.push_back(mk(0, 32'h0,        1, 32'h400000,   2'd0, 0, 0, 1, 32'h400000,   0, 32'h0,        0, 1, 32'h0,        1));
    vq.push_back(mk(0, 32'h0,        1, 32'h400000,   2'd2, 0, 0, 1, 32'h400000,   0, 32'h0,        0, 1, 32'h0,        1));
    vq.push_back(mk(1, 32'h20,       1, 32'h44,       2'd2, 0, 0, 1, 32'h44,       0, 32'h0,        0, 1, 32'h47464544, 0));
    vq.push_back(mk(0, 32'h0,        0, 32'h0,        2'd0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0));

    for (int i = 0; i < vq.size(); i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      @(negedge clk);
      drive(vq[i].ir, vq[i].ia, vq[i].dr, vq[i].da, vq[i].ds, vq[i].du);
      #1;
      chk({tag, "_if_gnt"},   32'(bus.if_gnt), 32'(vq[i].eig));
      chk({tag, "_d_gnt"},    32'(bus.d_gnt),  32'(vq[i].edg));
      chk({tag, "_rom_addr"}, bus.rom_addr,    vq[i].erom);
      @(posedge clk);
      #1;
      chk({tag, "_if_rvalid"}, 32'(bus.if_rvalid), 32'(vq[i].eiv));
      chk({tag, "_d_rvalid"},  32'(bus.d_rvalid),  32'(vq[i].edv));
      if (vq[i].eiv) begin
        chk({tag, "_if_rdata"}, bus.if_rdata,    vq[i].eid);
        chk({tag, "_if_err"},   32'(bus.if_err), 32'(vq[i].eie));
      end
      if (vq[i].edv) begin
        chk({tag, "_d_rdata"}, bus.d_rdata,    vq[i].edd);
        chk({tag, "_d_err"},   32'(bus.d_err), 32'(vq[i].ede));
      end
    end

    // Continuous contention: d,d,d,d,if repeating
    for (int i = 0; i < 10; i++) begin
      step($sformatf("starve%0d", i), 1'b1, 1'b1, (i % 5) == 4, (i % 5) != 4);
    end

    // A cycle with if_req low clears the partial starve count
    step("part0", 1'b1, 1'b1, 1'b0, 1'b1);
    step("part1", 1'b1, 1'b1, 1'b0, 1'b1);
    step("part2", 1'b1, 1'b1, 1'b0, 1'b1);
    step("clr",   1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step($sformatf("after_clr%0d", i), 1'b1, 1'b1, i == 4, i != 4);
    end

    // Reset asserted in the middle of a grant cycle
    step("idle", 1'b0, 1'b0, 1'b0, 1'b0);
    step("pre0", 1'b1, 1'b1, 1'b0, 1'b1);
    step("pre1", 1'b1, 1'b1, 1'b0, 1'b1);
    step("pre2", 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b1, 32'h20, 1'b1, 32'h40, 2'd2, 1'b0);
    #1;
    chk("rstmid_d_gnt", 32'(bus.d_gnt), 32'd1);
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rstmid_d_rvalid",  32'(bus.d_rvalid),  32'd0);
    chk("rstmid_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    chk("rstmid_d_rdata",   bus.d_rdata,        32'd0);
    chk("rstmid_d_err",     32'(bus.d_err),     32'd0);
    @(negedge clk);
    drive(1'b0, 32'd0, 1'b0, 32'd0, 2'd0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step($sformatf("post_rst%0d", i), 1'b1, 1'b1, i == 4, i != 4);
    end
    step("tail", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
